sha256_digest_hex_tx: RTL and testbench

- Downstream consumer of the SHA-256 GPIO core's digest byte stream (the dout/dvalid pair).
- Captures DIGEST_BYTES bytes into an internal buffer.
- Re-emits the digest as lowercase or uppercase ASCII hex characters, optionally terminated with CR LF.
- Output is a byte-wide valid/ready interface that feeds a UART TX or a host FIFO.

---
 rtl/sha256_pkg.sv | 19 +
 rtl/sha256_digest_hex_tx_hex_nibble_ascii.sv | 19 +
 rtl/sha256_digest_hex_tx.sv | 124 ++++++++++++
 tb/tb_sha256_digest_hex_tx.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sha256_pkg.sv
// sha256_pkg: shared constants and state type for the SHA-256 digest hex transmitter
package sha256_pkg;

    localparam int DIGEST_BYTES_DEF = 32;

    localparam logic [7:0] ASCII_CR      = 8'h0D;
    localparam logic [7:0] ASCII_LF      = 8'h0A;
    localparam logic [7:0] ASCII_ZERO    = 8'h30;
    localparam logic [7:0] ASCII_LOWER_A = 8'h61;
    localparam logic [7:0] ASCII_UPPER_A = 8'h41;

    typedef enum logic [1:0] {
        ST_COLLECT,
        ST_HEX,
        ST_CR,
        ST_LF
    } hex_tx_state_e;

endpackage

// File: rtl/sha256_digest_hex_tx_hex_nibble_ascii.sv
// hex_nibble_ascii: maps a 4-bit value to its ASCII hex digit
module hex_nibble_ascii
    import sha256_pkg::*;
#(
    parameter bit UPPERCASE = 1'b0
) (
    input  logic [3:0] nibble_i,
    output logic [7:0] ascii_o
);

    localparam logic [7:0] ALPHA = UPPERCASE ? ASCII_UPPER_A : ASCII_LOWER_A;

    // digits map onto '0'.., letters onto the selected alphabet base
    always_comb begin
        ascii_o = (nibble_i < 4'd10) ? ASCII_ZERO + {4'd0, nibble_i}
                                     : ALPHA + {4'd0, nibble_i} - 8'd10;
    end

endmodule

// File: rtl/sha256_digest_hex_tx.sv
// sha256_digest_hex_tx: collects a digest byte stream and re-emits it as ASCII hex over valid/ready
module sha256_digest_hex_tx
    import sha256_pkg::*;
#(
    parameter int DIGEST_BYTES = DIGEST_BYTES_DEF,
    parameter bit UPPERCASE    = 1'b0,
    parameter bit APPEND_CRLF  = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic       busy,
    output logic       frame_done,
    output logic       overrun
);

    localparam int WW = $clog2(DIGEST_BYTES);
    localparam int CW = $clog2(2 * DIGEST_BYTES);
    localparam logic [WW-1:0] WR_LAST = WW'(DIGEST_BYTES - 1);
    localparam logic [CW-1:0] CH_LAST = CW'(2 * DIGEST_BYTES - 1);

    hex_tx_state_e state_q;
    logic [WW-1:0] wr_idx_q;
    logic [CW-1:0] char_idx_q;
    logic [7:0]    buf_q [DIGEST_BYTES];
    logic [7:0]    tx_data_q;
    logic          tx_valid_q;
    logic          overrun_q;

    logic [CW-1:0] nxt_idx;
    logic [7:0]    nxt_byte;
    logic [3:0]    nxt_nib;
    logic [7:0]    nxt_char;
    logic          hs;
    logic          last_char;

    // character that becomes visible after the next advance: index 0 on frame entry, else the successor
    always_comb begin
        nxt_idx   = (state_q == ST_COLLECT) ? '0 : char_idx_q + 1'b1;
        nxt_byte  = buf_q[nxt_idx[CW-1:1]];
        nxt_nib   = nxt_idx[0] ? nxt_byte[3:0] : nxt_byte[7:4];
        hs        = tx_valid_q && tx_ready;
        last_char = char_idx_q == CH_LAST;
    end

    hex_nibble_ascii #(.UPPERCASE(UPPERCASE)) u_nib (
        .nibble_i (nxt_nib),
        .ascii_o  (nxt_char)
    );

    // digest storage; contents need no reset since every frame rewrites all entries before use
    always_ff @(posedge clk) begin
        if (in_valid && state_q == ST_COLLECT) buf_q[wr_idx_q] <= in_data;
    end

    // frame sequencing with registered tx_valid/tx_data so outputs never depend on tx_ready
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_COLLECT;
            wr_idx_q   <= '0;
            char_idx_q <= '0;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            overrun_q <= in_valid && state_q != ST_COLLECT;
            case (state_q)
                ST_COLLECT: begin
                    if (in_valid) begin
                        if (wr_idx_q == WR_LAST) begin
                            wr_idx_q   <= '0;
                            char_idx_q <= '0;
                            state_q    <= ST_HEX;
                            tx_valid_q <= 1'b1;
                            tx_data_q  <= nxt_char;
                        end else begin
                            wr_idx_q <= wr_idx_q + 1'b1;
                        end
                    end
                end
                ST_HEX: begin
                    if (tx_ready) begin
                        if (!last_char) begin
                            char_idx_q <= nxt_idx;
                            tx_data_q  <= nxt_char;
                        end else if (APPEND_CRLF) begin
                            state_q   <= ST_CR;
                            tx_data_q <= ASCII_CR;
                        end else begin
                            state_q    <= ST_COLLECT;
                            tx_valid_q <= 1'b0;
                        end
                    end
                end
                ST_CR: begin
                    if (tx_ready) begin
                        state_q   <= ST_LF;
                        tx_data_q <= ASCII_LF;
                    end
                end
                default: begin
                    if (tx_ready) begin
                        state_q    <= ST_COLLECT;
                        tx_valid_q <= 1'b0;
                    end
                end
            endcase
        end
    end

    // frame_done marks the accepting handshake of the final character itself
    always_comb begin
        frame_done = hs && (state_q == ST_LF || (state_q == ST_HEX && last_char && !APPEND_CRLF));
        busy       = state_q != ST_COLLECT || wr_idx_q != '0;
        tx_data    = tx_data_q;
        tx_valid   = tx_valid_q;
        overrun    = overrun_q;
    end

endmodule

// File: tb/tb_sha256_digest_hex_tx.sv
// tb_sha256_digest_hex_tx: randomized self-checking bench with a queue-based character model
module tb_sha256_digest_hex_tx;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] in_data;
    logic       in_valid, in_valid_b;
    logic       tx_ready;
    logic [7:0] tx_data_a, tx_data_b;
    logic       tx_valid_a, tx_valid_b;
    logic       busy_a, busy_b;
    logic       frame_done_a, frame_done_b;
    logic       overrun_a, overrun_b;
    logic [3:0] nib;
    logic [7:0] nib_lo, nib_hi;

    always #5 clk = ~clk;

    sha256_digest_hex_tx u_dut_a (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .tx_data(tx_data_a), .tx_valid(tx_valid_a), .tx_ready(tx_ready),
        .busy(busy_a), .frame_done(frame_done_a), .overrun(overrun_a)
    );

    sha256_digest_hex_tx #(.UPPERCASE(1'b1), .APPEND_CRLF(1'b0)) u_dut_b (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid_b),
        .tx_data(tx_data_b), .tx_valid(tx_valid_b), .tx_ready(tx_ready),
        .busy(busy_b), .frame_done(frame_done_b), .overrun(overrun_b)
    );

    hex_nibble_ascii #(.UPPERCASE(1'b0)) u_nib_lo (.nibble_i(nib), .ascii_o(nib_lo));
    hex_nibble_ascii #(.UPPERCASE(1'b1)) u_nib_hi (.nibble_i(nib), .ascii_o(nib_hi));

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0] exp_a[$];
    logic [7:0] exp_b[$];
    int hs_a = 0, hs_b = 0, fd_a = 0, fd_b = 0, ov_a = 0, ov_b = 0;
    logic [7:0] frame [32];
    logic [255:0] abc;
    bit rand_ready = 1'b0;
    logic stall_a = 1'b0, stall_b = 1'b0;
    logic [7:0] held_a = '0, held_b = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] hex_char(input logic [3:0] n, input bit up);
        string s;
        s = up ? "0123456789ABCDEF" : "0123456789abcdef";
        return s[n];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_abc();
        for (int i = 0; i < 32; i++) frame[i] = abc[255-8*i -: 8];
    endtask

    task automatic load_rand();
        for (int i = 0; i < 32; i++) frame[i] = 8'($urandom);
    endtask

    task automatic push_exp();
        for (int i = 0; i < 32; i++) begin
            exp_a.push_back(hex_char(frame[i][7:4], 1'b0));
            exp_a.push_back(hex_char(frame[i][3:0], 1'b0));
            exp_b.push_back(hex_char(frame[i][7:4], 1'b1));
            exp_b.push_back(hex_char(frame[i][3:0], 1'b1));
        end
        exp_a.push_back(8'h0D);
        exp_a.push_back(8'h0A);
    endtask

    // strobes the 32 frame bytes; returns one step into the cycle after the last strobe
    task automatic send_frame(input int gap_max);
        for (int i = 0; i < 32; i++) begin
            if (i > 0) repeat ($urandom_range(0, gap_max)) tick();
            in_data    = frame[i];
            in_valid   = 1'b1;
            in_valid_b = 1'b1;
            if (i == 31) begin
                push_exp();
                hs_a = 0;
                hs_b = 0;
                check("lat_pre_valid", 32'(tx_valid_a), 0);
            end
            tick();
            in_valid   = 1'b0;
            in_valid_b = 1'b0;
            if (i == 0) check("busy_first_byte", 32'(busy_a), 1);
        end
        check("lat_valid_a", 32'(tx_valid_a), 1);
        check("lat_data_a", 32'(tx_data_a), 32'(hex_char(frame[0][7:4], 1'b0)));
        check("lat_valid_b", 32'(tx_valid_b), 1);
        check("lat_data_b", 32'(tx_data_b), 32'(hex_char(frame[0][7:4], 1'b1)));
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((exp_a.size() > 0 || exp_b.size() > 0) && n < 2000) begin
            tick();
            n++;
        end
        check("drain_a", 32'(exp_a.size()), 0);
        check("drain_b", 32'(exp_b.size()), 0);
        tick();
        check("idle_busy_a", 32'(busy_a), 0);
        check("idle_busy_b", 32'(busy_b), 0);
        check("idle_valid_a", 32'(tx_valid_a), 0);
    endtask

    initial begin
        tx_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            tx_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    initial forever begin
        @(negedge clk);
        if (rst) stall_a = 1'b0;
        else begin
            if (stall_a) begin
                check("a_hold_valid", 32'(tx_valid_a), 1);
                check("a_hold_data", 32'(tx_data_a), 32'(held_a));
            end
            check("a_frame_done", 32'(frame_done_a), 32'(tx_valid_a && tx_ready && exp_a.size() == 1));
            if (frame_done_a) fd_a++;
            if (overrun_a) ov_a++;
            if (tx_valid_a && tx_ready) begin
                hs_a++;
                check("a_char", 32'(tx_data_a), exp_a.size() > 0 ? 32'(exp_a.pop_front()) : 32'h100);
            end
            stall_a = tx_valid_a && !tx_ready;
            held_a  = tx_data_a;
        end
    end

    initial forever begin
        @(negedge clk);
        if (rst) stall_b = 1'b0;
        else begin
            if (stall_b) begin
                check("b_hold_valid", 32'(tx_valid_b), 1);
                check("b_hold_data", 32'(tx_data_b), 32'(held_b));
            end
            check("b_frame_done", 32'(frame_done_b), 32'(tx_valid_b && tx_ready && exp_b.size() == 1));
            if (frame_done_b) fd_b++;
            if (overrun_b) ov_b++;
            if (tx_valid_b && tx_ready) begin
                hs_b++;
                check("b_char", 32'(tx_data_b), exp_b.size() > 0 ? 32'(exp_b.pop_front()) : 32'h100);
            end
            stall_b = tx_valid_b && !tx_ready;
            held_b  = tx_data_b;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        int fd0, fdb0, ov0, ovb0;
        rst        = 1'b1;
        in_valid   = 1'b0;
        in_valid_b = 1'b0;
        in_data    = '0;
        nib        = '0;
        abc = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
        repeat (3) @(posedge clk);
        #1;
        check("rst_tx_valid", 32'(tx_valid_a), 0);
        check("rst_busy", 32'(busy_a), 0);
        check("rst_frame_done", 32'(frame_done_a), 0);
        check("rst_overrun", 32'(overrun_a), 0);
        check("rst_tx_data", 32'(tx_data_a), 0);
        check("rst_tx_valid_b", 32'(tx_valid_b), 0);
        rst = 1'b0;
        tick();

        for (int n = 0; n < 16; n++) begin
            nib = 4'(n);
            #1;
            check("nib_lower", 32'(nib_lo), 32'(hex_char(nib, 1'b0)));
            check("nib_upper", 32'(nib_hi), 32'(hex_char(nib, 1'b1)));
        end

        // known "abc" digest, lowercase+CRLF on a, uppercase bare on b
        load_abc();
        fd0  = fd_a;
        fdb0 = fd_b;
        send_frame(0);
        check("abc_first_a", 32'(tx_data_a), 32'h62);
        check("abc_first_b", 32'(tx_data_b), 32'h42);
        tick();
        check("abc_second_b", 32'(tx_data_b), 32'h41);
        wait_idle();
        check("abc_chars_a", 32'(hs_a), 66);
        check("abc_chars_b", 32'(hs_b), 64);
        check("abc_done_a", 32'(fd_a - fd0), 1);
        check("abc_done_b", 32'(fd_b - fdb0), 1);

        // same digest under random backpressure
        rand_ready = 1'b1;
        send_frame(0);
        wait_idle();
        rand_ready = 1'b0;
        check("bp_chars_a", 32'(hs_a), 66);
        check("bp_chars_b", 32'(hs_b), 64);

        // random digest with idle gaps between strobes
        load_rand();
        send_frame(5);
        wait_idle();
        check("gap_chars_a", 32'(hs_a), 66);

        // stray strobes during HEX and on the LF handshake cycle
        load_rand();
        ov0  = ov_a;
        ovb0 = ov_b;
        send_frame(0);
        for (int k = 1; k <= 66; k++) begin
            if (k == 5 || k == 66) begin
                in_data  = 8'hFF;
                in_valid = 1'b1;
            end
            tick();
            in_valid = 1'b0;
        end
        tick();
        tick();
        check("ovr_count_a", 32'(ov_a - ov0), 2);
        check("ovr_count_b", 32'(ov_b - ovb0), 0);
        check("ovr_drain_a", 32'(exp_a.size()), 0);
        check("ovr_wr_idx_idle", 32'(busy_a), 0);
        load_rand();
        send_frame(0);
        wait_idle();
        check("ovr_next_chars", 32'(hs_a), 66);

        // reset while char_idx is 10
        load_abc();
        send_frame(0);
        repeat (10) tick();
        check("rst_mid_index", 32'(hs_a), 10);
        fd0  = fd_a;
        fdb0 = fd_b;
        rst  = 1'b1;
        #1;
        check("rst_mid_valid_a", 32'(tx_valid_a), 0);
        check("rst_mid_valid_b", 32'(tx_valid_b), 0);
        check("rst_mid_busy", 32'(busy_a), 0);
        exp_a.delete();
        exp_b.delete();
        tick();
        tick();
        rst = 1'b0;
        tick();
        check("rst_mid_no_done_a", 32'(fd_a - fd0), 0);
        check("rst_mid_no_done_b", 32'(fd_b - fdb0), 0);
        load_rand();
        send_frame(0);
        wait_idle();
        check("rst_next_chars", 32'(hs_a), 66);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
